fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 24 ++
 rtl/if_id_reg.sv | 30 +++
 rtl/fetch_stage.sv | 143 ++++++++++++++
 tb/tb_fetch_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the fetch stage: FSM state encoding,
// PC arithmetic constants and the IF/ID register layout with its bubble value.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } fetch_state_e;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INC   = 32'd4;
    localparam logic [31:0] PC_AHEAD = 32'd8;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus8;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{instr: '0, pc_plus8: '0, valid: 1'b0};

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall beats load; otherwise a bubble.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   flush,
    input  logic   stall,
    input  logic   load_en,
    input  if_id_t load_data,
    output if_id_t if_id
);

    if_id_t if_id_q, if_id_d;

    always_comb begin
        if_id_d = IF_ID_BUBBLE;
        if (flush)        if_id_d = IF_ID_BUBBLE;
        else if (stall)   if_id_d = if_id_q;
        else if (load_en) if_id_d = load_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) if_id_q <= IF_ID_BUBBLE;
        else       if_id_q <= if_id_d;
    end

    assign if_id = if_id_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, request FSM and one-entry hold buffer.
// Optional FETCH_PERF_CNT_EN adds the StallCntF busy-cycle counter.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        BranchTakenE,
    input  logic [31:0] ALUResultE,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus8D,
    output logic        ValidD,
    output logic        FetchBusyF
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] StallCntF
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  issued_pc_q, issued_pc_d;
    logic [31:0]  hold_instr_q, hold_instr_d;
    logic         redirect;
    logic [31:0]  redirect_target;
    logic         load_en;
    if_id_t       load_data;
    if_id_t       if_id;

    assign redirect        = BranchTakenE | PCSrcW;
    assign redirect_target = BranchTakenE ? ALUResultE : ResultW;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        issued_pc_d  = issued_pc_q;
        hold_instr_d = hold_instr_q;
        imem_req     = 1'b0;
        load_en      = 1'b0;
        load_data    = '{instr: imem_rdata, pc_plus8: issued_pc_q + PC_AHEAD, valid: 1'b1};
        unique case (state_q)
            S_REQ: begin
                imem_req = !StallF && !reset;
                // A grant coinciding with a redirect fetched the wrong path
                if (redirect) begin
                    pc_d = redirect_target;
                    if (imem_req && imem_gnt) state_d = S_DROP;
                end else if (imem_req && imem_gnt) begin
                    pc_d        = pc_q + PC_INC;
                    issued_pc_d = pc_q;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d    = redirect_target;
                    state_d = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    if (StallD) begin
                        hold_instr_d = imem_rdata;
                        state_d      = S_HOLD;
                    end else begin
                        load_en = 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_target;
                    state_d = S_REQ;
                end else if (!StallD) begin
                    load_en         = 1'b1;
                    load_data.instr = hold_instr_q;
                    state_d         = S_REQ;
                end
            end
            S_DROP: begin
                if (redirect)    pc_d    = redirect_target;
                if (imem_rvalid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            issued_pc_q  <= '0;
            hold_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            issued_pc_q  <= issued_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .reset    (reset),
        .flush    (FlushD),
        .stall    (StallD),
        .load_en  (load_en),
        .load_data(load_data),
        .if_id    (if_id)
    );

    assign imem_addr  = pc_q;
    assign InstrD     = if_id.instr;
    assign PCPlus8D   = if_id.pc_plus8;
    assign ValidD     = if_id.valid;
    assign FetchBusyF = (state_q == S_WAIT) || (state_q == S_DROP);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((FetchBusyF || state_q == S_HOLD) && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign StallCntF = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios push expected IF/ID
// contents; a negedge monitor pops and compares every newly loaded instruction.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, StallD, FlushD;
    logic        BranchTakenE, PCSrcW;
    logic [31:0] ALUResultE, ResultW;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD, PCPlus8D;
    logic        ValidD, FetchBusyF;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] StallCntF;
    logic [31:0] cnt_before;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc8;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned grants   = 0;
    int          lat      = 1;
    logic [31:0] special_addr, special_data;
    logic        held_last = 1'b0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .StallF      (StallF),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .BranchTakenE(BranchTakenE),
        .ALUResultE  (ALUResultE),
        .PCSrcW      (PCSrcW),
        .ResultW     (ResultW),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .InstrD      (InstrD),
        .PCPlus8D    (PCPlus8D),
        .ValidD      (ValidD),
        .FetchBusyF  (FetchBusyF)
`ifdef FETCH_PERF_CNT_EN
        ,
        .StallCntF   (StallCntF)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory: samples a request at negedge, responds lat cycles after the grant edge
    initial begin : memory_model
        logic [31:0] req_addr;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (!reset && imem_req && imem_gnt) begin
                req_addr = imem_addr;
                @(posedge clk);
                grants++;
                repeat (lat - 1) @(posedge clk);
                #1;
                imem_rvalid = 1'b1;
                imem_rdata  = (req_addr == special_addr) ? special_data : req_addr;
                @(posedge clk);
                #1;
                imem_rvalid = 1'b0;
                imem_rdata  = '0;
            end
        end
    end

    always @(posedge clk) held_last <= StallD && !FlushD;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && ValidD && !held_last) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_instr: got InstrD=%h PCPlus8D=%h, expected no new instruction", InstrD, PCPlus8D);
            end else begin
                e = sb.pop_front();
                chk("sb_instr", InstrD, e.instr);
                chk("sb_pcplus8", PCPlus8D, e.pc8);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_n(input int n);
        int unsigned target;
        target = grants + n;
        StallF = 1'b0;
        for (int i = 0; i < 40 && grants < target; i++) step();
        StallF = 1'b1;
        chk("grant_count", grants, target);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) step();
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        BranchTakenE = 1'b0; ALUResultE = '0; PCSrcW = 1'b0; ResultW = '0;
        imem_gnt = 1'b1; special_addr = 32'h0000_0FF0; special_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_validd", ValidD, 0);
        chk("rst_instrd", InstrD, 0);
        chk("rst_pcplus8d", PCPlus8D, 0);
        chk("rst_busy", FetchBusyF, 0);
        StallF = 1'b1;
        reset  = 1'b0;
        step();
        chk("addr_after_reset", imem_addr, 0);

        // Sequential fetches, rdata mirrors the address
        sb.push_back('{instr: 32'h0, pc8: 32'h8});
        sb.push_back('{instr: 32'h4, pc8: 32'hC});
        sb.push_back('{instr: 32'h8, pc8: 32'h10});
        fetch_n(3);
        drain();
        chk("bubble_after_load", ValidD, 0);

        // StallD across the response: held in HOLD, released one cycle after StallD falls
        special_addr = 32'h0000_000C;
        special_data = 32'hE3A0_1005;
        StallD = 1'b1;
        sb.push_back('{instr: 32'hE3A0_1005, pc8: 32'h14});
        fetch_n(1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_instr_held", InstrD, 0);
            chk("stall_valid_held", ValidD, 0);
        end
        chk("hold_not_busy", FetchBusyF, 0);
        StallD = 1'b0;
        step();
        chk("release_instr", InstrD, 32'hE3A0_1005);
        chk("release_pcplus8", PCPlus8D, 32'h14);
        chk("release_valid", ValidD, 1);
        step();
        chk("release_no_dup", ValidD, 0);
        chk("sb_after_hold", sb.size(), 0);

        // Branch during WAIT with 3-cycle latency: stale response dropped
        lat = 3;
        fetch_n(1);
        BranchTakenE = 1'b1; ALUResultE = 32'h0000_0100;
        step();
        BranchTakenE = 1'b0;
        chk("drop_busy", FetchBusyF, 1);
        chk("drop_no_req", imem_req, 0);
        chk("drop_valid0_a", ValidD, 0);
        step();
        chk("drop_valid0_b", ValidD, 0);
        step();
        chk("drop_valid0_c", ValidD, 0);
        chk("branch_addr", imem_addr, 32'h0000_0100);
        chk("drop_done_busy", FetchBusyF, 0);
        lat = 1;
        sb.push_back('{instr: 32'h100, pc8: 32'h108});
        fetch_n(1);
        drain();

        // Both redirects in REQ: branch wins
        BranchTakenE = 1'b1; ALUResultE = 32'h0000_0200;
        PCSrcW = 1'b1; ResultW = 32'h0000_0300;
        step();
        BranchTakenE = 1'b0; PCSrcW = 1'b0;
        chk("prio_addr", imem_addr, 32'h0000_0200);

        // Redirect in the same cycle as a grant: the granted fetch is wrong-path
        StallF = 1'b0; PCSrcW = 1'b1; ResultW = 32'h0000_0300;
        step();
        StallF = 1'b1; PCSrcW = 1'b0;
        chk("gnt_redirect_busy", FetchBusyF, 1);
        step();
        chk("gnt_redirect_addr", imem_addr, 32'h0000_0300);
        chk("gnt_redirect_valid", ValidD, 0);
        sb.push_back('{instr: 32'h300, pc8: 32'h308});
        fetch_n(1);
        drain();

        // FlushD with StallD beats the hold
        sb.push_back('{instr: 32'h304, pc8: 32'h30C});
        fetch_n(1);
        step();
        StallD = 1'b1;
        step();
        chk("stall_keeps_instr", InstrD, 32'h304);
        FlushD = 1'b1;
        step();
        chk("flush_valid", ValidD, 0);
        chk("flush_instr", InstrD, 0);
        chk("flush_pcplus8", PCPlus8D, 0);
        FlushD = 1'b0; StallD = 1'b0;
        chk("sb_after_flush", sb.size(), 0);

        // PC wrap from 0xFFFFFFFC
        PCSrcW = 1'b1; ResultW = 32'hFFFF_FFFC;
        step();
        PCSrcW = 1'b0;
        sb.push_back('{instr: 32'hFFFF_FFFC, pc8: 32'h0000_0004});
        fetch_n(1);
        chk("wrap_addr", imem_addr, 32'h0);
        drain();

        lat = 4;
`ifdef FETCH_PERF_CNT_EN
        cnt_before = StallCntF;
`endif
        sb.push_back('{instr: 32'h0, pc8: 32'h8});
        fetch_n(1);
        drain();
`ifdef FETCH_PERF_CNT_EN
        chk("stallcnt_delta", StallCntF - cnt_before, 32'd4);
`endif

        // Reset while WAIT: the late response is ignored
        lat = 3;
        fetch_n(1);
        reset = 1'b1; StallF = 1'b0;
        #1;
        chk("rst_wait_req", imem_req, 0);
        chk("rst_wait_busy", FetchBusyF, 0);
        @(posedge clk);
        #1;
        reset = 1'b0; StallF = 1'b1;
        step();
        chk("post_rst_valid", ValidD, 0);
        chk("post_rst_addr", imem_addr, 0);
        repeat (3) step();
        chk("post_rst_sb", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
